// File: rtl/bram_req_adapter.sv
// ---------------------------------------------------------------------------
// bram_req_adapter
//
// Front end for one port of a dual-port byte-enable BRAM. Accepts a
// ready/valid request stream (read, or byte-masked write), drives the BRAM
// port strobes combinationally from the accepted request, and captures the
// one-cycle-latency read data into an in-order response FIFO that the
// consumer drains with ready/valid back-pressure.
//
// Credit scheme: a request that produces a response is only accepted when
// (count + inflight) < RESP_DEPTH, so the FIFO slot for a read whose data is
// still one cycle away is already reserved. The FIFO can therefore never
// overflow, and req_ready depends on registered state only.
//
// Build option:
//   BRAM_REQ_WRITE_RESP_EN  when defined, writes also take a credit and push
//                           an acknowledgement entry (resp_data = 0,
//                           resp_is_write = 1) in order with read responses.
//                           When undefined, writes produce no response and
//                           resp_is_write is tied to 0.
//
// Ports:
//   clock                 system clock, rising edge
//   reset                 asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_byte_en           per-byte write enable
//   req_address           word address
//   req_data              write data
//   resp_valid/resp_ready response handshake (FIFO head)
//   resp_data             read data at the FIFO head (0 when empty)
//   resp_is_write         head entry is a write acknowledgement
//   bram_*                BRAM port strobes, address, write data, read data
// ---------------------------------------------------------------------------
module bram_req_adapter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,

   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [DATA_WIDTH/8-1:0] req_byte_en,
   input  logic [ADDR_WIDTH-1:0]   req_address,
   input  logic [DATA_WIDTH-1:0]   req_data,

   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_data,
   output logic                    resp_is_write,

   output logic                    bram_readEnable,
   output logic                    bram_writeEnable,
   output logic [DATA_WIDTH/8-1:0] bram_writeByteEnable,
   output logic [ADDR_WIDTH-1:0]   bram_address,
   output logic [DATA_WIDTH-1:0]   bram_writeData,
   input  logic [DATA_WIDTH-1:0]   bram_readData
);

   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RESP_DEPTH);

   // -----------------------------------------------------------------------
   // Run flag: low in reset, set on the first edge after release so that
   // req_ready comes up one cycle after reset is removed.
   // -----------------------------------------------------------------------
   logic run_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Handshake and credit check
   // -----------------------------------------------------------------------
   logic [CNT_W-1:0] count_q, count_d;
   logic             inflight_q, inflight_d;
   logic [CNT_W:0]   credits_used;
   logic             fire;
   logic             take_credit;
   logic             push;
   logic             pop;
   logic             push_wr;
   logic [DATA_WIDTH-1:0] push_data;

   assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign req_ready    = run_q & (credits_used < DEPTH_C);
   assign fire         = req_valid & req_ready;

   // -----------------------------------------------------------------------
   // BRAM drive: strobes qualified by fire, the rest passes straight through.
   // An all-zero byte-enable write is still issued; the BRAM ignores it.
   // -----------------------------------------------------------------------
   assign bram_readEnable      = fire & ~req_write;
   assign bram_writeEnable     = fire & req_write;
   assign bram_writeByteEnable = req_byte_en;
   assign bram_address         = req_address;
   assign bram_writeData       = req_data;

   // -----------------------------------------------------------------------
   // In-flight tracking
   // -----------------------------------------------------------------------
`ifdef BRAM_REQ_WRITE_RESP_EN
   logic inflight_wr_q, inflight_wr_d;

   assign take_credit   = fire;
   assign inflight_wr_d = fire & req_write;
   assign push_wr       = inflight_wr_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inflight_wr_q <= 1'b0;
      end else begin
         inflight_wr_q <= inflight_wr_d;
      end
   end
`else
   assign take_credit = fire & ~req_write;
   assign push_wr     = 1'b0;
`endif

   assign inflight_d = take_credit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   // The BRAM output is registered, so the cycle after issue it holds the
   // read data; write acknowledgements carry zero data instead.
   assign push      = inflight_q;
   assign push_data = push_wr ? '0 : bram_readData;

   // -----------------------------------------------------------------------
   // Response FIFO
   // -----------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

   assign resp_valid = (count_q != '0);
   assign pop        = resp_valid & resp_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO
   // is empty, so stale contents are never visible.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign resp_data = resp_valid ? mem_q[rd_ptr_q] : '0;

`ifdef BRAM_REQ_WRITE_RESP_EN
   logic [RESP_DEPTH-1:0] wr_flag_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_flag_q <= '0;
      end else if (push) begin
         wr_flag_q[wr_ptr_q] <= push_wr;
      end
   end

   assign resp_is_write = resp_valid & wr_flag_q[rd_ptr_q];
`else
   assign resp_is_write = 1'b0;
`endif

endmodule

// File: tb/tb_bram_req_adapter.sv
module tb_bram_req_adapter;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BW = DW / 8;

`ifdef BRAM_REQ_WRITE_RESP_EN
   localparam logic WR_RESP = 1'b1;
`else
   localparam logic WR_RESP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [BW-1:0] req_byte_en;
   logic [AW-1:0] req_address;
   logic [DW-1:0] req_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_data;
   logic          resp_is_write;
   logic          bram_readEnable;
   logic          bram_writeEnable;
   logic [BW-1:0] bram_writeByteEnable;
   logic [AW-1:0] bram_address;
   logic [DW-1:0] bram_writeData;
   logic [DW-1:0] bram_readData;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] exp_d [4];

   always #5 clock = ~clock;

   bram_req_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_DEPTH(4)) dut (
      .clock                (clock),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_write            (req_write),
      .req_byte_en          (req_byte_en),
      .req_address          (req_address),
      .req_data             (req_data),
      .resp_valid           (resp_valid),
      .resp_ready           (resp_ready),
      .resp_data            (resp_data),
      .resp_is_write        (resp_is_write),
      .bram_readEnable      (bram_readEnable),
      .bram_writeEnable     (bram_writeEnable),
      .bram_writeByteEnable (bram_writeByteEnable),
      .bram_address         (bram_address),
      .bram_writeData       (bram_writeData),
      .bram_readData        (bram_readData)
   );

   // BRAM behavioural model: byte-masked write, registered read.
   logic [DW-1:0] bram_mem [1 << AW];

   initial begin
      for (int i = 0; i < (1 << AW); i++) bram_mem[i] = '0;
      bram_readData = '0;
   end

   always @(posedge clock) begin
      if (bram_writeEnable) begin
         for (int b = 0; b < BW; b++) begin
            if (bram_writeByteEnable[b]) bram_mem[bram_address][8*b +: 8] <= bram_writeData[8*b +: 8];
         end
      end
      if (bram_readEnable) bram_readData <= bram_mem[bram_address];
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
      req_valid   = v;
      req_write   = w;
      req_address = a;
      req_data    = d;
      req_byte_en = be;
   endtask

   initial begin
      reset      = 1'b0;
      resp_ready = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0);

      // ---------------- reset state ----------------
      step();
      drive(1'b1, 1'b0, 8'd7, '0, '0);
      #1;
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_data", resp_data, '0);
      chk("rst_resp_is_write", resp_is_write, 1'b0);
      chk("rst_read_en", bram_readEnable, 1'b0);
      chk("rst_write_en", bram_writeEnable, 1'b0);
      drive(1'b0, 1'b0, '0, '0, '0);
      step();
      reset = 1'b1;
      #2;
      chk("rel_ready_before_edge", req_ready, 1'b0);
      step();
      chk("rel_ready_after_edge", req_ready, 1'b1);

      // ---------------- test 1: write then read, latency 2 ----------------
      resp_ready = 1'b1;
      drive(1'b1, 1'b1, 8'd5, 32'hA5A51234, 4'b1111);
      #1;
      chk("t1_wr_ready", req_ready, 1'b1);
      chk("t1_wr_en", bram_writeEnable, 1'b1);
      chk("t1_wr_rd_en", bram_readEnable, 1'b0);
      step();
      drive(1'b1, 1'b0, 8'd5, '0, '0);
      #1;
      chk("t1_rd_ready", req_ready, 1'b1);
      chk("t1_rd_en", bram_readEnable, 1'b1);
      chk("t1_rd_addr", bram_address, 8'd5);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("t1_k1_valid", resp_valid, WR_RESP);
      step();
      chk("t1_k2_valid", resp_valid, 1'b1);
      chk("t1_k2_data", resp_data, 32'hA5A51234);
      chk("t1_k2_is_write", resp_is_write, 1'b0);
      step();
      chk("t1_drained", resp_valid, 1'b0);

      // ---------------- test 2: byte-masked write, zero-mask write ----------------
      drive(1'b1, 1'b1, 8'd1, 32'h00000000, 4'b1111);
      step();
      drive(1'b1, 1'b1, 8'd1, 32'hDDDDEEEE, 4'b0011);
      #1;
      chk("t2_wr2_be", bram_writeByteEnable, 4'b0011);
      step();
      drive(1'b1, 1'b1, 8'd1, 32'hFFFFFFFF, 4'b0000);
      #1;
      chk("t2_zero_be_issued", bram_writeEnable, 1'b1);
      chk("t2_zero_be_value", bram_writeByteEnable, 4'b0000);
      step();
      drive(1'b1, 1'b0, 8'd1, '0, '0);
      #1;
      chk("t2_rd_ready", req_ready, 1'b1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("t2_k1_valid", resp_valid, WR_RESP);
      step();
      chk("t2_k2_valid", resp_valid, 1'b1);
      chk("t2_k2_data", resp_data, 32'h0000EEEE);
      step();

      // ---------------- preload addr 0, 2, 3 ----------------
      drive(1'b1, 1'b1, 8'd0, 32'h11111111, 4'b1111);
      step();
      drive(1'b1, 1'b1, 8'd2, 32'h22222222, 4'b1111);
      step();
      drive(1'b1, 1'b1, 8'd3, 32'h33333333, 4'b1111);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      repeat (4) step();
      chk("pre_idle_valid", resp_valid, 1'b0);

      exp_d[0] = 32'h11111111;
      exp_d[1] = 32'h0000EEEE;
      exp_d[2] = 32'h22222222;
      exp_d[3] = 32'h33333333;

      // ---------------- test 3: back-to-back reads, full throughput ----------------
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b1, 1'b0, AW'(i), '0, '0);
         else       drive(1'b0, 1'b0, '0, '0, '0);
         #1;
         if (i < 4) chk($sformatf("t3_ready_%0d", i), req_ready, 1'b1);
         if (i >= 2) begin
            chk($sformatf("t3_valid_%0d", i), resp_valid, 1'b1);
            chk($sformatf("t3_data_%0d", i), resp_data, exp_d[i-2]);
         end else begin
            chk($sformatf("t3_novalid_%0d", i), resp_valid, 1'b0);
         end
         step();
      end
      chk("t3_drained", resp_valid, 1'b0);

      // ---------------- test 4: back-pressure, credit limit ----------------
      resp_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, (i < 4) ? AW'(i) : AW'(4), '0, '0);
         #1;
         chk($sformatf("t4_ready_%0d", i), req_ready, (i < 4) ? 1'b1 : 1'b0);
         chk($sformatf("t4_rd_en_%0d", i), bram_readEnable, (i < 4) ? 1'b1 : 1'b0);
         step();
      end
      drive(1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("t4_hold_valid", resp_valid, 1'b1);
      chk("t4_hold_data_a", resp_data, exp_d[0]);
      step();
      chk("t4_hold_data_b", resp_data, exp_d[0]);
      chk("t4_full_ready", req_ready, 1'b0);
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t4_drain_valid_%0d", i), resp_valid, 1'b1);
         chk($sformatf("t4_drain_data_%0d", i), resp_data, exp_d[i]);
         if (i == 0) chk("t4_drain_ready_0", req_ready, 1'b0);
         step();
      end
      chk("t4_empty_valid", resp_valid, 1'b0);
      chk("t4_ready_back", req_ready, 1'b1);

      // ---------------- test 5: reset mid-operation ----------------
      resp_ready = 1'b0;
      drive(1'b1, 1'b0, 8'd3, '0, '0);
      step();
      drive(1'b1, 1'b0, 8'd2, '0, '0);
      step();
      drive(1'b1, 1'b0, 8'd0, '0, '0);
      #1;
      chk("t5_pre_valid", resp_valid, 1'b1);
      chk("t5_pre_data", resp_data, 32'h33333333);
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", resp_valid, 1'b0);
      chk("t5_rst_data", resp_data, '0);
      chk("t5_rst_ready", req_ready, 1'b0);
      chk("t5_rst_rd_en", bram_readEnable, 1'b0);
      drive(1'b0, 1'b0, '0, '0, '0);
      step();
      reset = 1'b1;
      resp_ready = 1'b1;
      step();
      chk("t5_rel_ready", req_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t5_no_stale_%0d", i), resp_valid, 1'b0);
         step();
      end
      drive(1'b1, 1'b0, 8'd0, '0, '0);
      #1;
      chk("t5_new_ready", req_ready, 1'b1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("t5_new_k1_valid", resp_valid, 1'b0);
      step();
      chk("t5_new_k2_valid", resp_valid, 1'b1);
      chk("t5_new_k2_data", resp_data, 32'h11111111);
      step();

`ifdef BRAM_REQ_WRITE_RESP_EN
      // ---------------- write acknowledgements in order with reads ----------------
      resp_ready = 1'b0;
      drive(1'b1, 1'b1, 8'd2, 32'hCAFEF00D, 4'b1111);
      step();
      drive(1'b1, 1'b0, 8'd2, '0, '0);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      step();
      chk("wr_ack_valid", resp_valid, 1'b1);
      chk("wr_ack_is_write", resp_is_write, 1'b1);
      chk("wr_ack_data", resp_data, '0);
      resp_ready = 1'b1;
      step();
      chk("wr_rd_valid", resp_valid, 1'b1);
      chk("wr_rd_is_write", resp_is_write, 1'b0);
      chk("wr_rd_data", resp_data, 32'hCAFEF00D);
      step();
      chk("wr_drained", resp_valid, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
